timebase_controller: RTL and testbench
======================================

Name: timebase_controller

Overview:
- Owns the scope's horizontal timebase.
- Takes debounced increment/decrement button pulses and maintains the requested sample period.
- Commits a new period only at a capture-frame boundary, so no trace mixes two timebases.
- Divides the ADC conversion tick into a sample-enable strobe and outputs the matching time-per-division value for the on-screen readout.

Parameters:
- SAMPLE_PERIOD_BITS, 6, width of the sample period register.
- TIME_PER_DIVISION_BITS, 10, width of the timePerDivision output.
- MAX_PERIOD, 63, largest legal sample period; must be < 2^SAMPLE_PERIOD_BITS.
- DEFAULT_PERIOD, 0, sample period loaded at reset.
- TPD_SCALE, 10, multiplier: timePerDivision = (samplePeriod+1)*TPD_SCALE.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- increment  input  1  one-cycle pulse: request a longer sample period.
- decrement  input  1  one-cycle pulse: request a shorter sample period.
- frameStart  input  1  one-cycle pulse from the capture logic at the start of each frame.
- adcTick  input  1  one-cycle pulse per completed ADC conversion.
- samplePeriod  output  SAMPLE_PERIOD_BITS  committed sample period.
- requestedPeriod  output  SAMPLE_PERIOD_BITS  period awaiting commit.
- pending  output  1  high while requestedPeriod != samplePeriod.
- sampleEnable  output  1  one-cycle strobe: store the current ADC sample.
- timePerDivision  output  TIME_PER_DIVISION_BITS  readout value for the committed period.

Behaviour:
- Reset (synchronous, priority over all inputs):
  - samplePeriod = requestedPeriod = DEFAULT_PERIOD; state = STABLE; pending = 0.
  - sampleEnable = 0; tick counter = 0.
  - timePerDivision = (DEFAULT_PERIOD+1)*TPD_SCALE, and both pipeline stages are preloaded to match, so there is no transient after reset.
- Request update:
  - increment alone: requestedPeriod += 1, saturating at MAX_PERIOD.
  - decrement alone: requestedPeriod -= 1, saturating at 0.
  - Both asserted in the same cycle: ignored.
  - requestedPeriod updates 1 cycle after the pulse.
- FSM:
  - STABLE -> PENDING when the registered requestedPeriod differs from samplePeriod.
  - PENDING -> STABLE on frameStart: samplePeriod <= requestedPeriod (value before any same-cycle increment/decrement).
  - PENDING -> STABLE without a commit if the request is stepped back to equal samplePeriod.
  - A button pulse coinciding with frameStart updates requestedPeriod and leaves or re-enters PENDING in the next cycle.
  - pending is registered and equals (state == PENDING).
- Sample divider (tick counter width SAMPLE_PERIOD_BITS):
  - adcTick with counter == samplePeriod: sampleEnable = 1 next cycle; counter <= 0.
  - adcTick otherwise: counter += 1; no strobe.
  - samplePeriod = 0: strobe on every adcTick.
  - frameStart (any state) without adcTick: counter <= 0.
  - frameStart with adcTick: the tick is sample 0 of the frame. sampleEnable = 1 next cycle; counter <= 1 if the newly committed period > 0, else 0.
  - The divider always uses the period in force after this cycle's commit.
- timePerDivision pipeline:
  - Stage 0: periodPlusOne <= samplePeriod+1 (SAMPLE_PERIOD_BITS+1 wide).
  - Stage 1: timePerDivision <= periodPlusOne*TPD_SCALE, truncated to TIME_PER_DIVISION_BITS.
  - Latency: 2 cycles after samplePeriod changes.

Optional Feature:
- Macro TIMEBASE_WRAP_EN.
- Defined: increment at MAX_PERIOD wraps requestedPeriod to 0; decrement at 0 wraps to MAX_PERIOD.
- Undefined: both limits saturate, as specified above.
- Nothing else changes.

Decomposition:
- Shared package timebase_pkg:
  - State encoding constants (STABLE, PENDING).
  - Default widths, MAX_PERIOD and TPD_SCALE constants, also reused by the display readout and the capture controller.
- One natural sub-module: tpd_pipeline, the 2-stage samplePeriod -> timePerDivision multiplier, instantiated once.

Test Plan:
- Reset then idle: samplePeriod = 0, timePerDivision = 10, pending = 0; adcTick every 4 cycles gives sampleEnable one cycle after each tick.
- Three increment pulses, then frameStart: requestedPeriod = 3 and pending = 1 until frameStart; samplePeriod = 3 next cycle; timePerDivision = 40 two cycles later; sampleEnable on every 4th adcTick.
- 70 increment pulses: requestedPeriod saturates at 63, or with TIMEBASE_WRAP_EN passes 63 -> 0 -> 6. Decrement at 0 stays 0, or goes to 63 with the macro.
- increment and decrement in the same cycle: requestedPeriod unchanged; increment coinciding with frameStart (request 2 -> 3, committed 1): samplePeriod = 2, pending = 1 afterwards.
- Committed period 2, frameStart coinciding with adcTick: sampleEnable next cycle; the next strobes follow adcTicks #3 and #6 counted from the frame.
- Request 5 then 4 steps back to 4 with committed 4 before frameStart: pending drops to 0; samplePeriod and timePerDivision never change.

Source files
------------

// File: rtl/timebase_pkg.sv
// Shared timebase constants, FSM state encoding and readout helper.
// Reused by display readout and capture controller. Optional macro: TIMEBASE_WRAP_EN.
package timebase_pkg;

    localparam int SAMPLE_PERIOD_BITS_DEF     = 6;
    localparam int TIME_PER_DIVISION_BITS_DEF = 10;
    localparam int MAX_PERIOD_DEF             = 63;
    localparam int DEFAULT_PERIOD_DEF         = 0;
    localparam int TPD_SCALE_DEF              = 10;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } tb_state_t;

    function automatic int tpd_of(input int period, input int scale);
        return (period + 1) * scale;
    endfunction

endpackage

// File: rtl/timebase_controller_tpd_pipeline.sv
// Two-stage samplePeriod -> timePerDivision multiplier.
// Both stages reset to the default period so the readout has no transient.
module tpd_pipeline
    import timebase_pkg::*;
#(
    parameter int SAMPLE_PERIOD_BITS     = SAMPLE_PERIOD_BITS_DEF,
    parameter int TIME_PER_DIVISION_BITS = TIME_PER_DIVISION_BITS_DEF,
    parameter int DEFAULT_PERIOD         = DEFAULT_PERIOD_DEF,
    parameter int TPD_SCALE              = TPD_SCALE_DEF
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [SAMPLE_PERIOD_BITS-1:0]     i_period,
    output logic [TIME_PER_DIVISION_BITS-1:0] o_tpd
);

    localparam int PW = SAMPLE_PERIOD_BITS + 1;
    localparam logic [PW-1:0] PPO_RST = PW'(DEFAULT_PERIOD + 1);
    localparam logic [TIME_PER_DIVISION_BITS-1:0] TPD_RST =
        TIME_PER_DIVISION_BITS'(tpd_of(DEFAULT_PERIOD, TPD_SCALE));

    logic [PW-1:0]                     r_ppo;
    logic [TIME_PER_DIVISION_BITS-1:0] r_tpd;
    logic [31:0]                       w_prod;

    assign w_prod = 32'(r_ppo) * 32'(TPD_SCALE);

    // Stage 0 forms period+1, stage 1 scales it into the readout value.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ppo <= PPO_RST;
            r_tpd <= TPD_RST;
        end else begin
            r_ppo <= {1'b0, i_period} + PW'(1);
            r_tpd <= w_prod[TIME_PER_DIVISION_BITS-1:0];
        end
    end

    assign o_tpd = r_tpd;

endmodule

// File: rtl/timebase_controller.sv
// Horizontal timebase: request stepping, frame-aligned commit, ADC tick divider.
// Optional macro TIMEBASE_WRAP_EN: request wraps at 0/MAX_PERIOD instead of saturating.
module timebase_controller
    import timebase_pkg::*;
#(
    parameter int SAMPLE_PERIOD_BITS     = SAMPLE_PERIOD_BITS_DEF,
    parameter int TIME_PER_DIVISION_BITS = TIME_PER_DIVISION_BITS_DEF,
    parameter int MAX_PERIOD             = MAX_PERIOD_DEF,
    parameter int DEFAULT_PERIOD         = DEFAULT_PERIOD_DEF,
    parameter int TPD_SCALE              = TPD_SCALE_DEF
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              increment,
    input  logic                              decrement,
    input  logic                              frameStart,
    input  logic                              adcTick,
    output logic [SAMPLE_PERIOD_BITS-1:0]     samplePeriod,
    output logic [SAMPLE_PERIOD_BITS-1:0]     requestedPeriod,
    output logic                              pending,
    output logic                              sampleEnable,
    output logic [TIME_PER_DIVISION_BITS-1:0] timePerDivision
);

    localparam int W = SAMPLE_PERIOD_BITS;
    localparam logic [W-1:0] MAXP = W'(MAX_PERIOD);
    localparam logic [W-1:0] DEFP = W'(DEFAULT_PERIOD);

    logic [W-1:0] r_req;
    logic [W-1:0] r_sample;
    logic [W-1:0] r_cnt;
    tb_state_t    r_state;
    logic         r_pending;
    logic         r_se;

    logic         w_inc;
    logic         w_dec;
    logic         w_commit;
    logic [W-1:0] w_period_next;
    logic [W-1:0] w_req_next;

    assign w_inc         = increment & ~decrement;
    assign w_dec         = decrement & ~increment;
    assign w_commit      = (r_state == PENDING) & frameStart;
    assign w_period_next = w_commit ? r_req : r_sample;

    // Next requested period: single-button steps, limit behaviour at the ends.
    always_comb begin
        w_req_next = r_req;
        if (w_inc) begin
            if (r_req == MAXP) begin
`ifdef TIMEBASE_WRAP_EN
                w_req_next = '0;
`else
                w_req_next = MAXP;
`endif
            end else begin
                w_req_next = r_req + W'(1);
            end
        end else if (w_dec) begin
            if (r_req == '0) begin
`ifdef TIMEBASE_WRAP_EN
                w_req_next = MAXP;
`else
                w_req_next = '0;
`endif
            end else begin
                w_req_next = r_req - W'(1);
            end
        end
    end

    // Register the requested period.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_req <= DEFP;
        end else begin
            r_req <= w_req_next;
        end
    end

    // Commit FSM: only a frame boundary may change the committed period.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= STABLE;
            r_pending <= 1'b0;
            r_sample  <= DEFP;
        end else begin
            unique case (r_state)
                STABLE: begin
                    if (r_req != r_sample) begin
                        r_state   <= PENDING;
                        r_pending <= 1'b1;
                    end
                end
                PENDING: begin
                    if (frameStart) begin
                        r_sample  <= r_req;
                        r_state   <= STABLE;
                        r_pending <= 1'b0;
                    end else if (r_req == r_sample) begin
                        r_state   <= STABLE;
                        r_pending <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Divide ADC ticks by period+1; the frame's first tick is always sampled.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
            r_se  <= 1'b0;
        end else begin
            r_se <= 1'b0;
            if (adcTick & frameStart) begin
                r_se  <= 1'b1;
                r_cnt <= (w_period_next != '0) ? W'(1) : '0;
            end else if (frameStart) begin
                r_cnt <= '0;
            end else if (adcTick) begin
                if (r_cnt == w_period_next) begin
                    r_se  <= 1'b1;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + W'(1);
                end
            end
        end
    end

    tpd_pipeline #(
        .SAMPLE_PERIOD_BITS     (SAMPLE_PERIOD_BITS),
        .TIME_PER_DIVISION_BITS (TIME_PER_DIVISION_BITS),
        .DEFAULT_PERIOD         (DEFAULT_PERIOD),
        .TPD_SCALE              (TPD_SCALE)
    ) u_tpd (
        .clock    (clock),
        .reset    (reset),
        .i_period (r_sample),
        .o_tpd    (timePerDivision)
    );

    assign samplePeriod    = r_sample;
    assign requestedPeriod = r_req;
    assign pending         = r_pending;
    assign sampleEnable    = r_se;

endmodule

// File: tb/tb_timebase_controller.sv
// Directed bench for timebase_controller: vector table plus corner sequences.
// Expectations follow TIMEBASE_WRAP_EN when it is defined.
module tb_timebase_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       increment;
    logic       decrement;
    logic       frameStart;
    logic       adcTick;
    logic [5:0] samplePeriod;
    logic [5:0] requestedPeriod;
    logic       pending;
    logic       sampleEnable;
    logic [9:0] timePerDivision;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic inc;
        logic dec;
        logic fs;
        logic tick;
        int   sp;
        int   rp;
        int   pend;
        int   se;
        int   tpd;
    } vec_t;

    vec_t vecs[$];

    timebase_controller dut (
        .clock           (clock),
        .reset           (reset),
        .increment       (increment),
        .decrement       (decrement),
        .frameStart      (frameStart),
        .adcTick         (adcTick),
        .samplePeriod    (samplePeriod),
        .requestedPeriod (requestedPeriod),
        .pending         (pending),
        .sampleEnable    (sampleEnable),
        .timePerDivision (timePerDivision)
    );

    always #5 clock = ~clock;

    task automatic add(input logic inc, input logic dec,
                       input logic fs, input logic tick,
                       input int sp, input int rp, input int pend,
                       input int se, input int tpd);
        vec_t v;
        v.inc = inc; v.dec = dec; v.fs = fs; v.tick = tick;
        v.sp = sp; v.rp = rp; v.pend = pend; v.se = se; v.tpd = tpd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic inc, input logic dec,
                       input logic fs, input logic tick);
        @(negedge clock);
        increment  = inc;
        decrement  = dec;
        frameStart = fs;
        adcTick    = tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(input string tag, input int sp, input int rp,
                           input int pend, input int se, input int tpd);
        chk({tag, ".samplePeriod"}, int'(samplePeriod), sp);
        chk({tag, ".requestedPeriod"}, int'(requestedPeriod), rp);
        chk({tag, ".pending"}, int'(pending), pend);
        chk({tag, ".sampleEnable"}, int'(sampleEnable), se);
        chk({tag, ".timePerDivision"}, int'(timePerDivision), tpd);
    endtask

    initial begin
        reset = 1'b1;
        increment = 1'b0; decrement = 1'b0;
        frameStart = 1'b0; adcTick = 1'b0;

        // period 0: every tick strobes
        add(0,0,0,1, 0,0,0,1,10);
        add(0,0,0,0, 0,0,0,0,10);
        add(0,0,0,0, 0,0,0,0,10);
        add(0,0,0,0, 0,0,0,0,10);
        add(0,0,0,1, 0,0,0,1,10);
        add(0,0,0,0, 0,0,0,0,10);
        // three increments then commit at frame start
        add(1,0,0,0, 0,1,0,0,10);
        add(1,0,0,0, 0,2,1,0,10);
        add(1,0,0,0, 0,3,1,0,10);
        add(0,0,0,0, 0,3,1,0,10);
        add(0,0,1,0, 3,3,0,0,10);
        add(0,0,0,0, 3,3,0,0,10);
        add(0,0,0,0, 3,3,0,0,40);
        // period 3: every 4th tick strobes
        add(0,0,0,1, 3,3,0,0,40);
        add(0,0,0,1, 3,3,0,0,40);
        add(0,0,0,1, 3,3,0,0,40);
        add(0,0,0,1, 3,3,0,1,40);
        add(0,0,0,0, 3,3,0,0,40);
        add(0,0,0,1, 3,3,0,0,40);
        // request stepped away and back: pending drops without commit
        add(1,0,0,0, 3,4,0,0,40);
        add(0,0,0,0, 3,4,1,0,40);
        add(0,1,0,0, 3,3,1,0,40);
        add(0,0,0,0, 3,3,0,0,40);
        add(0,0,0,0, 3,3,0,0,40);

        cyc(0,0,0,0);
        cyc(0,0,0,0);
        chk_all("reset", 0, 0, 0, 0, 10);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].inc, vecs[i].dec, vecs[i].fs, vecs[i].tick);
            chk_all($sformatf("vec%0d", i), vecs[i].sp, vecs[i].rp,
                    vecs[i].pend, vecs[i].se, vecs[i].tpd);
        end

        // both buttons together are ignored
        cyc(1,1,0,0);
        chk("both.req", int'(requestedPeriod), 3);
        chk("both.pend", int'(pending), 0);

        // commit 1, then increment coinciding with frame start
        cyc(0,1,0,0);
        cyc(0,1,0,0);
        cyc(0,0,0,0);
        cyc(0,0,0,0);
        chk("dn.pend", int'(pending), 1);
        cyc(0,0,1,0);
        chk("commit1.sp", int'(samplePeriod), 1);
        cyc(0,0,0,0);
        cyc(1,0,0,0);
        cyc(0,0,0,0);
        chk("req2.pend", int'(pending), 1);
        cyc(1,0,1,0);
        chk("coin.sp", int'(samplePeriod), 2);
        chk("coin.req", int'(requestedPeriod), 3);
        chk("coin.pend", int'(pending), 0);
        cyc(0,0,0,0);
        chk("coin.pend_next", int'(pending), 1);
        cyc(0,0,0,0);
        chk("coin.tpd", int'(timePerDivision), 30);

        // committed 2: frame start with tick is sample 0 of the frame
        cyc(0,1,0,0);
        cyc(0,0,0,0);
        chk("back2.pend", int'(pending), 0);
        cyc(0,0,1,1);
        chk("ftick.se", int'(sampleEnable), 1);
        for (int k = 2; k <= 7; k++) begin
            cyc(0,0,0,1);
            chk($sformatf("ftick%0d.se", k), int'(sampleEnable),
                (k == 3 || k == 6) ? 1 : 0);
            cyc(0,0,0,0);
            chk($sformatf("gap%0d.se", k), int'(sampleEnable), 0);
        end

        // frame start without tick clears the divider
        cyc(0,0,1,0);
        for (int k = 1; k <= 3; k++) begin
            cyc(0,0,0,1);
            chk($sformatf("clr%0d.se", k), int'(sampleEnable),
                (k == 3) ? 1 : 0);
        end

        // 70 increments from reset
        reset = 1'b1;
        cyc(0,0,0,0);
        reset = 1'b0;
        for (int k = 0; k < 70; k++) cyc(1,0,0,0);
`ifdef TIMEBASE_WRAP_EN
        chk("inc70.req", int'(requestedPeriod), 6);
`else
        chk("inc70.req", int'(requestedPeriod), 63);
`endif
        chk("inc70.sp", int'(samplePeriod), 0);
        chk("inc70.pend", int'(pending), 1);

        // decrement at zero
        reset = 1'b1;
        cyc(0,0,0,0);
        reset = 1'b0;
        cyc(0,1,0,0);
`ifdef TIMEBASE_WRAP_EN
        chk("dec0.req", int'(requestedPeriod), 63);
`else
        chk("dec0.req", int'(requestedPeriod), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
